// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator: counters, core-latency-matched blank/sync/RGB, VBLANK strobe.
// Optional cocktail flip of hpos/vpos when VIDEO_TIMING_FLIP_EN is defined.
module video_timing_gen #(
  parameter int RGB_W    = 8,
  parameter int CNT_W    = 9,
  parameter int H_ACTIVE = 256,
  parameter int H_FP     = 39,
  parameter int H_SYNC   = 31,
  parameter int H_BP     = 58,
  parameter int V_ACTIVE = 224,
  parameter int V_FP     = 3,
  parameter int V_SYNC   = 7,
  parameter int V_BP     = 29,
  parameter int PIPE_LAT = 2,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic             ce_pix,
`ifdef VIDEO_TIMING_FLIP_EN
  input  logic             flip,
`endif
  output logic [CNT_W-1:0] hpos,
  output logic [CNT_W-1:0] vpos,
  input  logic [RGB_W-1:0] rgb_in,
  output logic [RGB_W-1:0] rgb_out,
  output logic             hblank,
  output logic             vblank,
  output logic             hsync,
  output logic             vsync,
  output logic             vblank_irq
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT_C  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT_C  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] V_IRQ    = CNT_W'(V_ACTIVE - 1);
  localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  // Flag vector layout: {hb, vb, hs_active, vs_active}; idle = blanked, sync inactive.
  localparam logic [3:0] FLAGS_IDLE = 4'b1100;

  if (H_TOTAL >= (1 << CNT_W)) begin : g_bad_h
    $error("video_timing_gen: H_TOTAL does not fit in CNT_W bits");
  end
  if (V_TOTAL >= (1 << CNT_W)) begin : g_bad_v
    $error("video_timing_gen: V_TOTAL does not fit in CNT_W bits");
  end
  if (PIPE_LAT < 1) begin : g_bad_lat
    $error("video_timing_gen: PIPE_LAT must be at least 1");
  end

  logic [CNT_W-1:0] hcnt_q, hcnt_d;
  logic [CNT_W-1:0] vcnt_q, vcnt_d;
  logic             irq_q, irq_d;
  logic [3:0]       flags_raw;

  always_comb begin
    hcnt_d = hcnt_q;
    vcnt_d = vcnt_q;
    irq_d  = 1'b0;
    if (ce_pix) begin
      if (hcnt_q == H_LAST) begin
        hcnt_d = '0;
        vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + ONE;
        irq_d  = (vcnt_q == V_IRQ);
      end else begin
        hcnt_d = hcnt_q + ONE;
      end
    end
  end

  always_comb begin
    flags_raw[3] = (hcnt_q >= H_ACT_C);
    flags_raw[2] = (vcnt_q >= V_ACT_C);
    flags_raw[1] = (hcnt_q >= HS_START) && (hcnt_q < HS_END);
    flags_raw[0] = (vcnt_q >= VS_START) && (vcnt_q < VS_END);
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      hcnt_q <= '0;
      vcnt_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
      irq_q  <= irq_d;
    end
  end

  // Flag delay line matching the core's pixel latency; stage 0 takes the raw flags.
  logic [3:0] dly_q [PIPE_LAT];
  logic [3:0] dly_d [PIPE_LAT];

  for (genvar gi = 0; gi < PIPE_LAT; gi++) begin : g_dly
    if (gi == 0) begin : g_head
      always_comb dly_d[gi] = ce_pix ? flags_raw : dly_q[gi];
    end else begin : g_tail
      always_comb dly_d[gi] = ce_pix ? dly_q[gi-1] : dly_q[gi];
    end
    always_ff @(posedge clk_sys) begin
      if (reset) dly_q[gi] <= FLAGS_IDLE;
      else       dly_q[gi] <= dly_d[gi];
    end
  end

  logic [3:0]       flags_dly;
  logic [RGB_W-1:0] rgb_out_q, rgb_out_d;
  logic             hblank_q, hblank_d;
  logic             vblank_q, vblank_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;

  assign flags_dly = dly_q[PIPE_LAT-1];

  always_comb begin
    rgb_out_d = rgb_out_q;
    hblank_d  = hblank_q;
    vblank_d  = vblank_q;
    hsync_d   = hsync_q;
    vsync_d   = vsync_q;
    if (ce_pix) begin
      hblank_d  = flags_dly[3];
      vblank_d  = flags_dly[2];
      hsync_d   = flags_dly[1] ? HS_POL : ~HS_POL;
      vsync_d   = flags_dly[0] ? VS_POL : ~VS_POL;
      rgb_out_d = (flags_dly[3] | flags_dly[2]) ? '0 : rgb_in;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      rgb_out_q <= '0;
      hblank_q  <= 1'b1;
      vblank_q  <= 1'b1;
      hsync_q   <= ~HS_POL;
      vsync_q   <= ~VS_POL;
    end else begin
      rgb_out_q <= rgb_out_d;
      hblank_q  <= hblank_d;
      vblank_q  <= vblank_d;
      hsync_q   <= hsync_d;
      vsync_q   <= vsync_d;
    end
  end

  assign rgb_out    = rgb_out_q;
  assign hblank     = hblank_q;
  assign vblank     = vblank_q;
  assign hsync      = hsync_q;
  assign vsync      = vsync_q;
  assign vblank_irq = irq_q;

`ifdef VIDEO_TIMING_FLIP_EN
  logic flip_q, flip_d;
  logic at_origin, flip_eff;

  // At the frame origin the live flip input already applies, so pixel (0,0) is mirrored too.
  always_comb begin
    at_origin = (hcnt_q == '0) && (vcnt_q == '0);
    flip_d    = (ce_pix && at_origin) ? flip : flip_q;
    flip_eff  = at_origin ? flip : flip_q;
    hpos      = (flip_eff && (hcnt_q < H_ACT_C)) ? (H_ACT_C - ONE - hcnt_q) : hcnt_q;
    vpos      = (flip_eff && (vcnt_q < V_ACT_C)) ? (V_ACT_C - ONE - vcnt_q) : vcnt_q;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) flip_q <= 1'b0;
    else       flip_q <= flip_d;
  end
`else
  assign hpos = hcnt_q;
  assign vpos = vcnt_q;
`endif

endmodule
